// File: rtl/adder_chk_pkg.sv
// Shared definitions for the adder result checker: FSM encoding and pipeline limits.
package adder_chk_pkg;

  typedef enum logic [1:0] {
    CHK_IDLE  = 2'd0,
    CHK_RUN   = 2'd1,
    CHK_DRAIN = 2'd2
  } chk_state_e;

  localparam int MAX_LATENCY = 8;

endpackage

// File: rtl/adder_result_checker_if.sv
// Observation bus between an adder under check and its result checker:
// the operands driven into the adder and the adder's registered result.
interface adder_result_checker_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output in_valid, output a, output b, output sum, output cout);
  modport slave  (input  in_valid, input  a, input  b, input  sum, input  cout);

endinterface

// File: rtl/chk_delay_line.sv
// Fixed-depth shift register carrying a valid bit alongside a data word;
// any_vld reports whether anything is still in flight.
module chk_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  output logic             any_vld
);

  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;

  always_comb begin
    vld_d     = vld_q;
    data_d    = data_q;
    vld_d[0]  = in_vld;
    data_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_data = data_q[DEPTH-1];
  assign any_vld  = |vld_q;

endmodule

// File: rtl/adder_result_checker.sv
// Golden-model checker for registered adders: delays the expected {cout,sum} by the
// adder latency, compares, keeps saturating pass/fail counts and captures the first failure.
module adder_result_checker
  import adder_chk_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clear,
  adder_result_checker_if.slave  bus,
  output logic                   busy,
  output logic [CNT_W-1:0]       pass_cnt,
  output logic [CNT_W-1:0]       fail_cnt,
  output logic                   err,
  output logic [WIDTH-1:0]       first_fail_a,
  output logic [WIDTH-1:0]       first_fail_b,
  output logic [WIDTH:0]         first_fail_got
);

  localparam int EXP_W = WIDTH + 1;
  localparam int DW    = 2 * WIDTH + EXP_W;
  // Out-of-range latencies are clamped into the supported 1..MAX_LATENCY window.
  localparam int DEPTH = (LATENCY < 1) ? 1 :
                         (LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  chk_state_e       state_q, state_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] ffa_q, ffa_d;
  logic [WIDTH-1:0] ffb_q, ffb_d;
  logic [EXP_W-1:0] ffgot_q, ffgot_d;

  logic             sample;
  logic [EXP_W-1:0] exp_in;
  logic [DW-1:0]    line_in;
  logic             line_vld;
  logic [DW-1:0]    line_out;
  logic             line_any;
  logic [WIDTH-1:0] a_dly, b_dly;
  logic [EXP_W-1:0] exp_dly;
  logic [EXP_W-1:0] got;

  assign sample  = (state_q == CHK_RUN) && en && bus.in_valid;
  assign exp_in  = EXP_W'(bus.a) + EXP_W'(bus.b);
  assign line_in = {bus.a, bus.b, exp_in};
  assign {a_dly, b_dly, exp_dly} = line_out;
  assign got     = {bus.cout, bus.sum};

  chk_delay_line #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (sample),
    .in_data  (line_in),
    .out_vld  (line_vld),
    .out_data (line_out),
    .any_vld  (line_any)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CHK_IDLE:  if (en) state_d = CHK_RUN;
      CHK_RUN:   if (!en) state_d = CHK_DRAIN;
      CHK_DRAIN: begin
        if (en)             state_d = CHK_RUN;
        else if (!line_any) state_d = CHK_IDLE;
      end
      default:   state_d = CHK_IDLE;
    endcase
  end

  always_comb begin
    pass_d  = pass_q;
    fail_d  = fail_q;
    err_d   = err_q;
    ffa_d   = ffa_q;
    ffb_d   = ffb_q;
    ffgot_d = ffgot_q;
    if (line_vld) begin
      if (got == exp_dly) begin
        pass_d = sat_inc(pass_q);
      end else begin
        fail_d = sat_inc(fail_q);
        err_d  = 1'b1;
        if (!err_q) begin
          ffa_d   = a_dly;
          ffb_d   = b_dly;
          ffgot_d = got;
        end
      end
    end
    // Clear takes priority over a compare landing on the same edge.
    if (clear) begin
      pass_d  = '0;
      fail_d  = '0;
      err_d   = 1'b0;
      ffa_d   = '0;
      ffb_d   = '0;
      ffgot_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CHK_IDLE;
      pass_q  <= '0;
      fail_q  <= '0;
      err_q   <= 1'b0;
      ffa_q   <= '0;
      ffb_q   <= '0;
      ffgot_q <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      ffa_q   <= ffa_d;
      ffb_q   <= ffb_d;
      ffgot_q <= ffgot_d;
    end
  end

  assign busy           = (state_q != CHK_IDLE);
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign err            = err_q;
  assign first_fail_a   = ffa_q;
  assign first_fail_b   = ffb_q;
  assign first_fail_got = ffgot_q;

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench: three checker instances (default, 4-bit counters, latency 3)
// each observing a small registered adder model with an optional result override.
module tb_adder_result_checker;
  import adder_chk_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- instance 1: WIDTH=8, LATENCY=1, CNT_W=16
  adder_result_checker_if #(.WIDTH(8)) b1 ();
  logic        en1, clr1, busy1, err1, frc1;
  logic [8:0]  frc1_val;
  logic [15:0] pass1, fail1;
  logic [7:0]  ffa1, ffb1;
  logic [8:0]  ffg1;

  always @(posedge clk) {b1.cout, b1.sum} <= frc1 ? frc1_val : {1'b0, b1.a} + {1'b0, b1.b};

  adder_result_checker #(.WIDTH(8), .LATENCY(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .clear(clr1), .bus(b1.slave),
    .busy(busy1), .pass_cnt(pass1), .fail_cnt(fail1), .err(err1),
    .first_fail_a(ffa1), .first_fail_b(ffb1), .first_fail_got(ffg1)
  );

  // ---------------- instance 2: CNT_W=4 saturation
  adder_result_checker_if #(.WIDTH(8)) b2 ();
  logic        en2, busy2, err2;
  logic [3:0]  pass2, fail2;
  logic [7:0]  ffa2, ffb2;
  logic [8:0]  ffg2;

  always @(posedge clk) {b2.cout, b2.sum} <= {1'b0, b2.a} + {1'b0, b2.b};

  adder_result_checker #(.WIDTH(8), .LATENCY(1), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .clear(1'b0), .bus(b2.slave),
    .busy(busy2), .pass_cnt(pass2), .fail_cnt(fail2), .err(err2),
    .first_fail_a(ffa2), .first_fail_b(ffb2), .first_fail_got(ffg2)
  );

  // ---------------- instance 3: LATENCY=3, adder modelled as 3 register stages
  adder_result_checker_if #(.WIDTH(8)) b3 ();
  logic        en3, busy3, err3, frc3;
  logic [15:0] pass3, fail3;
  logic [7:0]  ffa3, ffb3;
  logic [8:0]  ffg3, r3_1, r3_2;

  always @(posedge clk) begin
    r3_1 <= frc3 ? 9'h1ff : {1'b0, b3.a} + {1'b0, b3.b};
    r3_2 <= r3_1;
    {b3.cout, b3.sum} <= r3_2;
  end

  adder_result_checker #(.WIDTH(8), .LATENCY(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .clear(1'b0), .bus(b3.slave),
    .busy(busy3), .pass_cnt(pass3), .fail_cnt(fail3), .err(err3),
    .first_fail_a(ffa3), .first_fail_b(ffb3), .first_fail_got(ffg3)
  );

  initial begin
    rst_n = 1'b0;
    en1 = 0; clr1 = 0; frc1 = 0; frc1_val = '0;
    en2 = 0; en3 = 0; frc3 = 0;
    b1.in_valid = 0; b1.a = 0; b1.b = 0;
    b2.in_valid = 0; b2.a = 0; b2.b = 0;
    b3.in_valid = 0; b3.a = 0; b3.b = 0;
    #12;
    chk("rst_busy",  32'(busy1), 0);
    chk("rst_pass",  32'(pass1), 0);
    chk("rst_fail",  32'(fail1), 0);
    chk("rst_err",   32'(err1),  0);
    chk("rst_ffgot", 32'(ffg1),  0);
    rst_n = 1'b1;

    // Basic pass: 1+1
    en1 = 1; step();
    chk("run_busy", 32'(busy1), 1);
    b1.a = 1; b1.b = 1; b1.in_valid = 1; step();
    b1.in_valid = 0; step();
    chk("t1_pass", 32'(pass1), 1);
    chk("t1_fail", 32'(fail1), 0);
    chk("t1_err",  32'(err1),  0);

    // Carry out: 255+1 = 9'h100
    b1.a = 255; b1.b = 1; b1.in_valid = 1; step();
    b1.in_valid = 0; step();
    chk("t2_pass", 32'(pass1), 2);
    chk("t2_fail", 32'(fail1), 0);

    // Two back-to-back forced mismatches; first one is captured
    b1.a = 1; b1.b = 1; b1.in_valid = 1; frc1 = 1; frc1_val = 9'h003; step();
    b1.a = 2; b1.b = 2; frc1_val = 9'h007; step();
    b1.in_valid = 0; frc1 = 0; step();
    chk("t3_fail",  32'(fail1), 2);
    chk("t3_pass",  32'(pass1), 2);
    chk("t3_err",   32'(err1),  1);
    chk("t3_ffa",   32'(ffa1),  1);
    chk("t3_ffb",   32'(ffb1),  1);
    chk("t3_ffgot", 32'(ffg1),  32'h003);

    // Clear on a compare edge: that compare is dropped
    b1.a = 3; b1.b = 4; b1.in_valid = 1; step();
    b1.in_valid = 0; clr1 = 1; step();
    clr1 = 0;
    chk("clr_pass",  32'(pass1), 0);
    chk("clr_fail",  32'(fail1), 0);
    chk("clr_err",   32'(err1),  0);
    chk("clr_ffa",   32'(ffa1),  0);
    chk("clr_ffgot", 32'(ffg1),  0);
    b1.a = 5; b1.b = 6; b1.in_valid = 1; step();
    b1.in_valid = 0; step();
    chk("post_clr_pass", 32'(pass1), 1);

    // Saturation with 4-bit counters: 20 passing samples
    en2 = 1; step();
    for (int i = 0; i < 20; i++) begin
      b2.a = 8'(i); b2.b = 8'(3 * i); b2.in_valid = 1; step();
    end
    b2.in_valid = 0; step();
    chk("sat_pass", 32'(pass2), 15);
    chk("sat_fail", 32'(fail2), 0);
    step(); step();
    chk("sat_hold", 32'(pass2), 15);

    // Latency 3: four samples, then drain with three in flight
    en3 = 1; step();
    for (int i = 0; i < 4; i++) begin
      b3.a = 8'(10 + i); b3.b = 8'(20 + i); b3.in_valid = 1; step();
    end
    b3.in_valid = 0; en3 = 0; step();
    chk("drn_state", 32'(dut3.state_q), 32'(CHK_DRAIN));
    chk("drn_busy",  32'(busy3), 1);
    chk("drn_pass2", 32'(pass3), 2);
    step(); step();
    chk("drn_pass4", 32'(pass3), 4);
    chk("drn_busy2", 32'(busy3), 1);
    step();
    chk("idle_busy", 32'(busy3), 0);
    b3.a = 9; b3.b = 9; b3.in_valid = 1; frc3 = 1;
    for (int i = 0; i < 5; i++) step();
    b3.in_valid = 0; frc3 = 0;
    chk("idle_pass", 32'(pass3), 4);
    chk("idle_fail", 32'(fail3), 0);

    // Async reset mid-stream discards an in-flight (would-be failing) sample
    b1.a = 7; b1.b = 7; b1.in_valid = 1; frc1 = 1; frc1_val = 9'h000; step();
    b1.in_valid = 0; frc1 = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pass", 32'(pass1), 0);
    chk("arst_busy", 32'(busy1), 0);
    chk("arst_p2",   32'(pass2), 0);
    #2 rst_n = 1'b1;
    step();
    chk("arst_nocmp_fail", 32'(fail1), 0);
    chk("arst_nocmp_err",  32'(err1),  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
